// File: rtl/nonrestoring_divider.sv
// Multi-cycle unsigned non-restoring divider on a ripple add/subtract slice chain.
// Takes WIDTH+1 cycles from the accepted start to done, or one cycle for a zero divisor.
module nonrestoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_ZERO = 2'd3
    } state_t;

    // One-bit add/sub slices rippled together: op=1 subtracts (invert b, carry-in 1), op=0 adds.
    function automatic logic [WIDTH:0] addsub(input logic [WIDTH:0] a,
                                              input logic [WIDTH:0] b,
                                              input logic           op);
        logic             c;
        logic             bi;
        logic [WIDTH:0]   s;
        c = op;
        s = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            bi   = b[i] ^ op;
            s[i] = a[i] ^ bi ^ c;
            c    = (a[i] & bi) | (c & (a[i] ^ bi));
        end
        return s;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shift_s;
    logic [WIDTH:0]   dext_s;
    logic [WIDTH:0]   step_s;
    logic [WIDTH:0]   fix_s;

    // Datapath and next-state logic for the control FSM.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        // The add/sub decision uses the sign of P before the shift; the shifted
        // value may wrap in WIDTH+1 bits but the step result always fits again.
        shift_s = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
        dext_s  = {1'b0, d_q};
        step_s  = addsub(shift_s, dext_s, ~p_q[WIDTH]);
        fix_s   = p_q[WIDTH] ? addsub(p_q, dext_s, 1'b0) : p_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    q_d     = dividend_i;
                    d_d     = divisor_i;
                    p_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = (divisor_i == '0) ? S_ZERO : S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                p_d = step_s;
                q_d = {q_q[WIDTH-2:0], ~step_s[WIDTH]};
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FIX: begin
                p_d     = fix_s;
                quot_d  = q_q;
                rem_d   = fix_s[WIDTH-1:0];
                dbz_d   = 1'b0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_ZERO: begin
                quot_d  = '1;
                rem_d   = q_q;
                dbz_d   = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign quotient_o    = quot_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Self-checking bench for nonrestoring_divider: directed cases with literal results
// plus a long back-to-back random sweep compared every cycle against a behavioural model.
module tb_nonrestoring_divider;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    nonrestoring_divider #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .busy_o        (busy),
        .done_o        (done),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .div_by_zero_o (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: latency countdown plus plain / and % on the latched operands.
    logic             m_busy = 1'b0;
    logic             m_done = 1'b0;
    logic [WIDTH-1:0] m_q    = '0;
    logic [WIDTH-1:0] m_r    = '0;
    logic             m_z    = 1'b0;
    logic [WIDTH-1:0] m_a    = '0;
    logic [WIDTH-1:0] m_b    = '0;
    int               m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
            m_z    <= 1'b0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy <= 1'b1;
                    m_a    <= dividend;
                    m_b    <= divisor;
                    m_left <= (divisor == 8'd0) ? 1 : WIDTH + 1;
                end
            end else if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                if (m_b == 8'd0) begin
                    m_q <= 8'hFF;
                    m_r <= m_a;
                    m_z <= 1'b1;
                end else begin
                    m_q <= m_a / m_b;
                    m_r <= m_a % m_b;
                    m_z <= 1'b0;
                end
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("quotient", quotient, m_q);
            check("remainder", remainder, m_r);
            check("div_by_zero", div_by_zero, m_z);
            check("done_overlap", done & prev_done, 0);
            prev_done <= done;
        end else begin
            prev_done <= 1'b0;
        end
    end

    task automatic do_div(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic ez, input int elat, input bit pulse3);
        int lat;
        int ndone;
        @(posedge clk); #1;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        lat   = 0;
        ndone = 0;
        for (int n = 1; n <= 20; n++) begin
            if (pulse3 && n == 3) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (done) begin
                ndone++;
                if (lat == 0) lat = n;
            end
        end
        check("lit_quotient", quotient, eq);
        check("lit_remainder", remainder, er);
        check("lit_div_by_zero", div_by_zero, ez);
        check("lit_latency", lat, elat);
        check("lit_done_count", ndone, 1);
        check("model_quotient", m_q, eq);
        check("model_remainder", m_r, er);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dones;
        int cyc;
        int mode;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_dbz", div_by_zero, 0);
        rst_n = 1'b1;

        do_div(8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 9, 1'b0);
        do_div(8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9, 1'b0);
        do_div(8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 9, 1'b0);
        do_div(8'd0,   8'd3,   8'd0,   8'd0,   1'b0, 9, 1'b0);
        do_div(8'd128, 8'd128, 8'd1,   8'd0,   1'b0, 9, 1'b0);
        do_div(8'd37,  8'd0,   8'd255, 8'd37,  1'b1, 1, 1'b0);
        do_div(8'd9,   8'd3,   8'd3,   8'd0,   1'b0, 9, 1'b0);
        do_div(8'd200, 8'd6,   8'd33,  8'd2,   1'b0, 9, 1'b1);

        // Reset in the middle of 77/5 aborts it and clears outputs without a clock edge.
        @(posedge clk); #1;
        start    = 1'b1;
        dividend = 8'd77;
        divisor  = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_dbz", div_by_zero, 0);
        repeat (12) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_div(8'd77, 8'd5, 8'd15, 8'd2, 1'b0, 9, 1'b0);

        // Back-to-back random sweep with start held high.
        dones = 0;
        cyc   = 0;
        @(posedge clk); #1;
        start = 1'b1;
        while (dones < 2000 && cyc < 40000) begin
            mode     = int'($urandom_range(0, 9));
            dividend = (mode == 3) ? 8'd255 : 8'($urandom);
            case (mode)
                0:       divisor = 8'd0;
                1:       divisor = 8'd1;
                2:       divisor = dividend;
                4:       divisor = 8'd255;
                default: divisor = 8'($urandom);
            endcase
            @(negedge clk);
            if (done) dones++;
            @(posedge clk); #1;
            cyc++;
        end
        check("sweep_done_count", dones, 2000);
        start = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
